crc_req_sched: RTL and testbench

CRC_REQ_SCHED -- requirements
Module: crc_req_sched

---
 rtl/crc_req_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_crc_req_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_req_sched.sv
// ---------------------------------------------------------------------------
// crc_req_sched
//   Two-requester scheduler in front of a byte-serial CRC engine. Each
//   requester signals a job by toggling its req*_tgl line. Pending jobs are
//   arbitrated round-robin. The granted job seeds the engine with a one-cycle
//   eng_init pulse, streams len bytes with src_vld flow control, and finishes
//   with a one-cycle done pulse to its requester.
//
// Ports
//   clk                 clock, rising-edge
//   rst_n               asynchronous active-low reset
//   req0_tgl, req1_tgl  request toggles; each level change is one job
//   len0, len1          job byte counts, sampled only at grant
//   src_vld0, src_vld1  requester data byte valid this cycle
//   eng_init            one-cycle seed-load pulse to the CRC engine
//   eng_en              engine consumes one byte this cycle
//   eng_sel             requester feeding the engine (held for the job)
//   eng_last            final byte of the job (only together with eng_en)
//   done0, done1        one-cycle completion pulse per requester
//   ovf0, ovf1          sticky flag: a request was dropped
//   busy                FSM is not idle
// ---------------------------------------------------------------------------
module crc_req_sched #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_tgl,
    input  logic             req1_tgl,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             src_vld0,
    input  logic             src_vld1,
    output logic             eng_init,
    output logic             eng_en,
    output logic             eng_sel,
    output logic             eng_last,
    output logic             done0,
    output logic             done1,
    output logic             ovf0,
    output logic             ovf1,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       hist_q;
    logic [1:0]       pend_q;
    logic [1:0]       pend_d;
    logic [1:0]       ovf_q;
    logic [1:0]       ovf_d;
    logic             ptr_q;
    logic             ptr_d;
    logic             sel_q;
    logic             sel_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    logic [1:0]       req_s;
    logic [1:0]       edge_s;
    logic [1:0]       clr_s;
    logic             grant_s;
    logic [LEN_W-1:0] len_gnt_s;
    logic             vld_sel_s;
    logic             en_s;
    logic             last_s;

    assign req_s     = {req1_tgl, req0_tgl};
    assign edge_s    = req_s ^ hist_q;
    assign vld_sel_s = sel_q ? src_vld1 : src_vld0;
    assign en_s      = (state_q == S_RUN) & vld_sel_s;
    assign last_s    = en_s & (cnt_q == CNT_ONE);
    assign len_gnt_s = grant_s ? len1 : len0;

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        grant_s = 1'b0;
        if (pend_q == 2'b11) begin
            grant_s = ~ptr_q;
        end else if (pend_q[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Pending clear for the served requester happens in the FIN cycle.
    always_comb begin
        clr_s = 2'b00;
        if (state_q == S_FIN) begin
            clr_s = sel_q ? 2'b10 : 2'b01;
        end else begin
            clr_s = 2'b00;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                // Empty job skips RUN; the CRC result is just the seed.
                if (cnt_q != CNT_ZERO) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs; eng_en follows src_vld combinationally so a stall costs no cycle.
    always_comb begin
        eng_init = 1'b0;
        eng_en   = 1'b0;
        eng_last = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_INIT: begin
                eng_init = 1'b1;
                busy     = 1'b1;
            end
            S_RUN: begin
                eng_en   = en_s;
                eng_last = last_s;
                busy     = 1'b1;
            end
            S_FIN: begin
                done0 = clr_s[0];
                done1 = clr_s[1];
                busy  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign eng_sel = sel_q;
    assign ovf0    = ovf_q[0];
    assign ovf1    = ovf_q[1];

    // Datapath next-state: pending/overflow bookkeeping, grant latch, byte counter.
    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        ptr_d = ptr_q;
        // A new edge always sets pending, even in the cycle it is being cleared.
        pend_d = edge_s | (pend_q & ~clr_s);
        ovf_d  = ovf_q | (edge_s & pend_q & ~clr_s);
        if ((state_q == S_IDLE) && (|pend_q)) begin
            cnt_d = len_gnt_s;
            sel_d = grant_s;
        end else if (en_s) begin
            // RUN always holds cnt >= 1, so this cannot wrap.
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (state_q == S_FIN) begin
            ptr_d = sel_q;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Datapath registers; the pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b00;
            pend_q <= 2'b00;
            ovf_q  <= 2'b00;
            ptr_q  <= 1'b1;
            sel_q  <= 1'b0;
            cnt_q  <= CNT_ZERO;
        end else begin
            hist_q <= req_s;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            ptr_q  <= ptr_d;
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_crc_req_sched.sv
// ---------------------------------------------------------------------------
// tb_crc_req_sched
//   Directed bench for crc_req_sched. The driver issues jobs and pushes the
//   hand-computed expected job record (requester, INIT cycle, done cycle,
//   byte count) into a queue. An independent monitor follows eng_init /
//   eng_en / eng_last / done and pops a record on every done pulse.
//   Cycle numbers: cyc increments at each rising edge; a request driven in
//   cycle c is sampled at edge c+1, so an isolated job of length L shows
//   INIT in cycle c+2 and done in cycle c+3+L.
// ---------------------------------------------------------------------------
module tb_crc_req_sched;

    typedef struct {
        logic sel;
        int   init_c;
        int   done_c;
        int   nbytes;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req0_tgl;
    logic       req1_tgl;
    logic [7:0] len0;
    logic [7:0] len1;
    logic       src_vld0;
    logic       src_vld1;
    logic       eng_init;
    logic       eng_en;
    logic       eng_sel;
    logic       eng_last;
    logic       done0;
    logic       done1;
    logic       ovf0;
    logic       ovf1;
    logic       busy;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    crc_req_sched #(.LEN_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0_tgl (req0_tgl),
        .req1_tgl (req1_tgl),
        .len0     (len0),
        .len1     (len1),
        .src_vld0 (src_vld0),
        .src_vld1 (src_vld1),
        .eng_init (eng_init),
        .eng_en   (eng_en),
        .eng_sel  (eng_sel),
        .eng_last (eng_last),
        .done0    (done0),
        .done1    (done1),
        .ovf0     (ovf0),
        .ovf1     (ovf1),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input int i, input int d, input int n);
        exp_t e;
        e.sel    = s;
        e.init_c = i;
        e.done_c = d;
        e.nbytes = n;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({eng_init, eng_en, eng_sel, eng_last, done0, done1, ovf0, ovf1, busy}), 0);
    endtask

    // Monitor: samples on the falling edge, independent of the driver.
    initial begin : monitor
        logic in_job;
        logic job_sel;
        int   init_seen;
        int   byte_cnt;
        int   last_cnt;
        exp_t e;
        in_job    = 1'b0;
        job_sel   = 1'b0;
        init_seen = 0;
        byte_cnt  = 0;
        last_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_job   = 1'b0;
                byte_cnt = 0;
                last_cnt = 0;
            end else begin
                if (eng_init) begin
                    if (in_job) fail_now("init_during_job");
                    in_job    = 1'b1;
                    job_sel   = eng_sel;
                    init_seen = cyc;
                    byte_cnt  = 0;
                    last_cnt  = 0;
                end
                chk("busy", int'(busy), int'(in_job));
                if (in_job) chk("sel_stable", int'(eng_sel), int'(job_sel));
                if (eng_en) begin
                    byte_cnt++;
                    if (!in_job) fail_now("en_outside_job");
                end
                if (eng_last) begin
                    last_cnt++;
                    chk("last_with_en", int'(eng_en), 1);
                    if (exp_q.size() > 0) chk("last_position", byte_cnt, exp_q[0].nbytes);
                    else fail_now("last_without_job");
                end
                if (done0 || done1) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_who", int'({done1, done0}), e.sel ? 2 : 1);
                        chk("init_cycle", init_seen, e.init_c);
                        chk("done_cycle", cyc, e.done_c);
                        chk("byte_count", byte_cnt, e.nbytes);
                        chk("last_count", last_cnt, (e.nbytes != 0) ? 1 : 0);
                        chk("grant_sel", int'(job_sel), int'(e.sel));
                    end
                    in_job = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver.
    initial begin : driver
        int c;
        rst_n    = 1'b0;
        req0_tgl = 1'b0;
        req1_tgl = 1'b0;
        len0     = 8'd0;
        len1     = 8'd0;
        src_vld0 = 1'b0;
        src_vld1 = 1'b0;
        wait_cyc(3);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        wait_cyc(2);

        // Single job, len 3, data always valid.
        c = cyc;
        len0 = 8'd3; src_vld0 = 1'b1; req0_tgl = ~req0_tgl;
        push(1'b0, c + 2, c + 6, 3);
        wait_cyc(8);

        // Empty job on requester 1: INIT then FIN, no bytes.
        c = cyc;
        len1 = 8'd0; req1_tgl = ~req1_tgl;
        push(1'b1, c + 2, c + 3, 0);
        wait_cyc(6);

        // Simultaneous requests, two rounds: grant order 0,1,0,1.
        for (int r = 0; r < 2; r++) begin
            c = cyc;
            len0 = 8'd2; len1 = 8'd2; src_vld0 = 1'b1; src_vld1 = 1'b1;
            req0_tgl = ~req0_tgl; req1_tgl = ~req1_tgl;
            push(1'b0, c + 2, c + 5, 2);
            push(1'b1, c + 7, c + 10, 2);
            wait_cyc(13);
        end

        // len 4 with a 3-cycle source stall after two bytes.
        c = cyc;
        len0 = 8'd4; src_vld0 = 1'b1; req0_tgl = ~req0_tgl;
        push(1'b0, c + 2, c + 10, 4);
        wait_cyc(5);
        src_vld0 = 1'b0;
        wait_cyc(3);
        src_vld0 = 1'b1;
        wait_cyc(6);
        chk("ovf0_before", int'(ovf0), 0);

        // req0 toggled twice while pending during a req1 job: one drop, one job.
        c = cyc;
        len1 = 8'd5; len0 = 8'd1; req1_tgl = ~req1_tgl;
        push(1'b1, c + 2, c + 8, 5);
        push(1'b0, c + 10, c + 12, 1);
        wait_cyc(3);
        req0_tgl = ~req0_tgl;
        wait_cyc(2);
        req0_tgl = ~req0_tgl;
        wait_cyc(2);
        chk("ovf0_set", int'(ovf0), 1);
        chk("ovf1_clear", int'(ovf1), 0);
        wait_cyc(8);
        chk("ovf0_sticky", int'(ovf0), 1);

        // Toggle sampled in its own FIN cycle: second job, no overflow.
        c = cyc;
        len1 = 8'd2; req1_tgl = ~req1_tgl;
        push(1'b1, c + 2, c + 5, 2);
        push(1'b1, c + 7, c + 10, 2);
        wait_cyc(5);
        req1_tgl = ~req1_tgl;
        wait_cyc(8);
        chk("ovf1_fin_toggle", int'(ovf1), 0);

        // Reset during RUN: outputs drop at once, no done afterwards.
        len0 = 8'd6; req0_tgl = ~req0_tgl;
        wait_cyc(4);
        chk("busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midjob_reset_outputs");
        req0_tgl = 1'b0;
        req1_tgl = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(12);
        chk("idle_after_reset", int'(busy), 0);

        // Toggle input high at reset release counts as one request.
        rst_n = 1'b0;
        req1_tgl = 1'b1; len1 = 8'd1; src_vld1 = 1'b1;
        wait_cyc(2);
        c = cyc;
        rst_n = 1'b1;
        push(1'b1, c + 2, c + 4, 1);
        wait_cyc(8);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
